keypad_pin_lock: RTL and testbench
==================================

Name: keypad_pin_lock

Overview:
- Consumer of the keypad event stream (key_valid / key_value: 0-9 digits, 10 = '*', 11 = '#').
- Collects a fixed-length BCD PIN and compares it against a stored PIN.
- Drives unlock / lockout status and allows the stored PIN to be changed while unlocked.
- Feeds the 7-segment display (entry buffer, digit count) and the door/LED logic.

Parameters:
- PIN_LEN, 4: number of digits per PIN (1..8).
- DEFAULT_PIN, 16'h1234: stored PIN after reset; BCD, most significant digit first; width 4*PIN_LEN.
- MAX_FAIL, 3: consecutive failed checks that trigger lockout (1..15).
- LOCK_CYCLES, 50000000: lockout duration in clk cycles (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle key event strobe
- key_value  in  4  key code: 0-9 digit, 10 '*', 11 '#', 12-15 ignored
- entry_buf  out  4*PIN_LEN  BCD digits entered so far; newest digit in bits [3:0]
- digit_cnt  out  4  digits currently held (0..PIN_LEN)
- unlocked  out  1  level; high in OPEN and SET
- locked  out  1  level; high in LOCKOUT
- fail_pulse  out  1  one-cycle pulse per failed check
- set_done  out  1  one-cycle pulse when a new PIN is stored
- fail_cnt  out  4  consecutive failure count
- state  out  3  ENTRY=0, CHECK=1, OPEN=2, SET=3, LOCKOUT=4

Behaviour:
- Reset (rst low, async), all values then hold until the first clk edge after release:
  - state = ENTRY
  - entry_buf = 0, digit_cnt = 0, fail_cnt = 0
  - unlocked = 0, locked = 0, fail_pulse = 0, set_done = 0
  - stored PIN = DEFAULT_PIN, lockout timer = 0
- General rules:
  - All outputs are registered.
  - A key accepted on edge N is visible after edge N.
  - key_valid with key_value 12-15 is ignored in every state.
- Digit entry (ENTRY and SET):
  - If digit_cnt < PIN_LEN: entry_buf <= {entry_buf[4*PIN_LEN-5:0], digit}; digit_cnt++.
  - If digit_cnt == PIN_LEN: the digit is dropped, no change.
- ENTRY:
  - '*': clear entry_buf and digit_cnt.
  - '#': go to CHECK.
- CHECK (exactly one cycle, all keys ignored):
  - Match requires digit_cnt == PIN_LEN and entry_buf == stored PIN.
  - Match: -> OPEN; unlocked = 1; fail_cnt = 0.
  - Mismatch, including a short entry: fail_pulse = 1 for one cycle; fail_cnt++.
    - If the incremented fail_cnt == MAX_FAIL: -> LOCKOUT; locked = 1; timer = LOCK_CYCLES.
    - Otherwise: -> ENTRY.
  - Both outcomes clear entry_buf and digit_cnt.
  - Latency: '#' on edge N gives CHECK after N; result visible after N+1.
- OPEN:
  - Digits ignored.
  - '#': relock; -> ENTRY; unlocked = 0.
  - '*': -> SET with cleared buffer; unlocked stays 1.
- SET:
  - Digits are entered as above.
  - '*': abort; -> OPEN; buffer cleared; stored PIN unchanged.
  - '#' with digit_cnt == PIN_LEN: stored PIN <= entry_buf; set_done = 1 for one cycle; -> OPEN; buffer cleared.
  - '#' with digit_cnt < PIN_LEN: ignored; remain in SET.
- LOCKOUT:
  - All keys ignored.
  - Timer decrements once per cycle.
  - When the timer == 1: -> ENTRY next edge; locked = 0; fail_cnt = 0. Total time in LOCKOUT is exactly LOCK_CYCLES cycles.
- fail_cnt saturates at MAX_FAIL and never wraps.
- The stored PIN is writable only from SET. It is reloaded to DEFAULT_PIN on every reset, including a reset mid-operation in any state.

Test Plan (PIN_LEN=4, DEFAULT_PIN=16'h1234, MAX_FAIL=3, LOCK_CYCLES=16):
- Keys 1,2,3,4,# -> entry_buf=16'h1234 with digit_cnt=4 before '#'; state CHECK for 1 cycle; then state=OPEN, unlocked=1, fail_cnt=0.
- Keys 1,2,3,4,5,# -> 5th digit dropped (entry_buf=16'h1234); unlocked=1. Keys 1,2,*,3,4 -> entry_buf=16'h0034, digit_cnt=2.
- Three entries of 9,9,9,9,# -> fail_pulse 3 times; fail_cnt 1,2,3; state=LOCKOUT, locked=1. Keys during lockout are ignored. Exactly 16 cycles later state=ENTRY, locked=0, fail_cnt=0.
- Short entry 1,2,# -> fail_pulse=1, fail_cnt=1, buffer cleared. Then 1,2,3,4,# -> unlocked=1, fail_cnt=0.
- From OPEN: *,5,6,7,8,# -> set_done pulse; state=OPEN. Then # -> ENTRY. Then 1,2,3,4,# fails; 5,6,7,8,# unlocks. *,5,# in SET -> '#' ignored; * aborts with stored PIN unchanged.
- Assert rst low while in SET after digits 5,6 -> immediately all outputs at reset values; stored PIN=16'h1234 (1,2,3,4,# unlocks after release).

Source files
------------

// File: rtl/keypad_pin_lock.sv
// PIN lock controller: collects BCD digits from a keypad event stream, checks them
// against a stored PIN, and manages unlock, PIN change and timed lockout.
module keypad_pin_lock #(
  parameter int                     PIN_LEN     = 4,
  parameter logic [4*PIN_LEN-1:0]   DEFAULT_PIN = 16'h1234,
  parameter int                     MAX_FAIL    = 3,
  parameter int                     LOCK_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_value,
  output logic [4*PIN_LEN-1:0] entry_buf,
  output logic [3:0]           digit_cnt,
  output logic                 unlocked,
  output logic                 locked,
  output logic                 fail_pulse,
  output logic                 set_done,
  output logic [3:0]           fail_cnt,
  output logic [2:0]           state
);

  localparam int             BUF_W    = 4 * PIN_LEN;
  localparam int             TIMER_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [3:0]     PIN_LEN_C  = 4'(PIN_LEN);
  localparam logic [3:0]     MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [TIMER_W-1:0] LOCK_C = TIMER_W'(LOCK_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_SET     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BUF_W-1:0]     entry_buf_q, entry_buf_d;
  logic [3:0]           digit_cnt_q, digit_cnt_d;
  logic [3:0]           fail_cnt_q, fail_cnt_d;
  logic [BUF_W-1:0]     stored_q, stored_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 unlocked_q, unlocked_d;
  logic                 locked_q, locked_d;
  logic                 fail_pulse_q, fail_pulse_d;
  logic                 set_done_q, set_done_d;

  logic                 key_digit, key_star, key_hash;
  logic                 buf_full;
  logic                 pin_match;
  logic [BUF_W-1:0]     buf_shift;
  logic [3:0]           fail_inc;

  // Codes 12-15 decode to nothing, so they fall through every state untouched.
  assign key_digit = key_valid && (key_value <= 4'd9);
  assign key_star  = key_valid && (key_value == 4'd10);
  assign key_hash  = key_valid && (key_value == 4'd11);

  assign buf_full  = (digit_cnt_q == PIN_LEN_C);
  assign pin_match = buf_full && (entry_buf_q == stored_q);
  assign fail_inc  = (fail_cnt_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_q + 4'd1;

  always_comb begin
    buf_shift      = entry_buf_q << 4;
    buf_shift[3:0] = key_value;
  end

  always_comb begin
    state_d      = state_q;
    entry_buf_d  = entry_buf_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    stored_d     = stored_q;
    timer_d      = timer_q;
    fail_pulse_d = 1'b0;
    set_done_d   = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (key_digit) begin
          if (!buf_full) begin
            entry_buf_d = buf_shift;
            digit_cnt_d = digit_cnt_q + 4'd1;
          end
        end else if (key_star) begin
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end else if (key_hash) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        entry_buf_d = '0;
        digit_cnt_d = '0;
        if (pin_match) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
        end else begin
          fail_pulse_d = 1'b1;
          fail_cnt_d   = fail_inc;
          if (fail_inc == MAX_FAIL_C) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCK_C;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (key_hash) begin
          state_d = ST_ENTRY;
        end else if (key_star) begin
          state_d     = ST_SET;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end
      end

      ST_SET: begin
        if (key_digit) begin
          if (!buf_full) begin
            entry_buf_d = buf_shift;
            digit_cnt_d = digit_cnt_q + 4'd1;
          end
        end else if (key_star) begin
          state_d     = ST_OPEN;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end else if (key_hash && buf_full) begin
          stored_d    = entry_buf_q;
          set_done_d  = 1'b1;
          state_d     = ST_OPEN;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end
      end

      ST_LOCKOUT: begin
        // Timer was loaded with LOCK_CYCLES on entry; leaving at 1 gives exactly that many cycles.
        if (timer_q == TIMER_ONE) begin
          state_d    = ST_ENTRY;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        state_d     = ST_ENTRY;
        entry_buf_d = '0;
        digit_cnt_d = '0;
      end
    endcase
  end

  // Status levels follow the next state so they are registered alongside it.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN) || (state_d == ST_SET);
    locked_d   = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ENTRY;
      entry_buf_q  <= '0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      stored_q     <= DEFAULT_PIN;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
      set_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_buf_q  <= entry_buf_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      stored_q     <= stored_d;
      timer_q      <= timer_d;
      unlocked_q   <= unlocked_d;
      locked_q     <= locked_d;
      fail_pulse_q <= fail_pulse_d;
      set_done_q   <= set_done_d;
    end
  end

  assign entry_buf  = entry_buf_q;
  assign digit_cnt  = digit_cnt_q;
  assign unlocked   = unlocked_q;
  assign locked     = locked_q;
  assign fail_pulse = fail_pulse_q;
  assign set_done   = set_done_q;
  assign fail_cnt   = fail_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_keypad_pin_lock.sv
// Bench for keypad_pin_lock: directed scenarios plus random key traffic, every cycle
// compared against a digit-list reference model of the lock.
module tb_keypad_pin_lock;

  localparam int PIN_LEN     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;
  localparam logic [15:0] DEF_PIN = 16'h1234;

  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        key_valid = 1'b0;
  logic [3:0]  key_value = 4'd0;
  logic [15:0] entry_buf;
  logic [3:0]  digit_cnt;
  logic        unlocked, locked, fail_pulse, set_done;
  logic [3:0]  fail_cnt;
  logic [2:0]  state;

  keypad_pin_lock #(
    .PIN_LEN(PIN_LEN), .DEFAULT_PIN(DEF_PIN), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst_n), .key_valid(key_valid), .key_value(key_value),
    .entry_buf(entry_buf), .digit_cnt(digit_cnt), .unlocked(unlocked), .locked(locked),
    .fail_pulse(fail_pulse), .set_done(set_done), .fail_cnt(fail_cnt), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: the PIN as a list of digits, lockout as cycles remaining
  int m_mode;
  int m_entry[$];
  int m_stored[PIN_LEN];
  int m_fails;
  int m_lock_left;
  bit m_fail_pulse, m_set_done;

  task automatic model_reset();
    m_mode = M_ENTRY;
    m_entry.delete();
    for (int i = 0; i < PIN_LEN; i++) m_stored[i] = int'((DEF_PIN >> (4 * (PIN_LEN - 1 - i))) & 16'hf);
    m_fails = 0;
    m_lock_left = 0;
    m_fail_pulse = 0;
    m_set_done = 0;
  endtask

  function automatic bit entry_matches();
    if (m_entry.size() != PIN_LEN) return 0;
    for (int i = 0; i < PIN_LEN; i++) if (m_entry[i] != m_stored[i]) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] exp_buf();
    logic [31:0] v = 0;
    foreach (m_entry[i]) v = v * 16 + 32'(m_entry[i]);
    return v;
  endfunction

  task automatic model_step(input bit v, input int k);
    bit is_digit = v && k <= 9;
    bit is_star  = v && k == 10;
    bit is_hash  = v && k == 11;
    m_fail_pulse = 0;
    m_set_done = 0;
    case (m_mode)
      M_ENTRY: begin
        if (is_digit) begin
          if (m_entry.size() < PIN_LEN) m_entry.push_back(k);
        end else if (is_star) m_entry.delete();
        else if (is_hash) m_mode = M_CHECK;
      end
      M_CHECK: begin
        if (entry_matches()) begin
          m_mode = M_OPEN;
          m_fails = 0;
        end else begin
          m_fail_pulse = 1;
          if (m_fails < MAX_FAIL) m_fails++;
          if (m_fails == MAX_FAIL) begin
            m_mode = M_LOCK;
            m_lock_left = LOCK_CYCLES;
          end else m_mode = M_ENTRY;
        end
        m_entry.delete();
      end
      M_OPEN: begin
        if (is_hash) m_mode = M_ENTRY;
        else if (is_star) begin
          m_mode = M_SET;
          m_entry.delete();
        end
      end
      M_SET: begin
        if (is_digit) begin
          if (m_entry.size() < PIN_LEN) m_entry.push_back(k);
        end else if (is_star) begin
          m_mode = M_OPEN;
          m_entry.delete();
        end else if (is_hash && m_entry.size() == PIN_LEN) begin
          for (int i = 0; i < PIN_LEN; i++) m_stored[i] = m_entry[i];
          m_set_done = 1;
          m_mode = M_OPEN;
          m_entry.delete();
        end
      end
      default: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode = M_ENTRY;
          m_fails = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(key_valid, int'(key_value));
  end

  // scoreboard: every output compared on the falling edge
  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("state", 32'(state), 32'(m_mode));
      check("entry_buf", 32'(entry_buf), exp_buf());
      check("digit_cnt", 32'(digit_cnt), 32'(m_entry.size()));
      check("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN || m_mode == M_SET));
      check("locked", 32'(locked), 32'(m_mode == M_LOCK));
      check("fail_pulse", 32'(fail_pulse), 32'(m_fail_pulse));
      check("set_done", 32'(set_done), 32'(m_set_done));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
    end
  end

  // driver tasks
  task automatic press(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_value = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    key_value = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_pin(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_state"}, 32'(state), 32'd0);
    check({pfx, "_entry_buf"}, 32'(entry_buf), 32'd0);
    check({pfx, "_digit_cnt"}, 32'(digit_cnt), 32'd0);
    check({pfx, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
    check({pfx, "_unlocked"}, 32'(unlocked), 32'd0);
    check({pfx, "_locked"}, 32'(locked), 32'd0);
    check({pfx, "_fail_pulse"}, 32'(fail_pulse), 32'd0);
    check({pfx, "_set_done"}, 32'(set_done), 32'd0);
  endtask

  initial begin
    model_reset();
    #23;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    idle(2);

    // correct PIN: CHECK for one cycle, then OPEN
    press(1); press(2); press(3); press(4);
    check("pin_buf", 32'(entry_buf), 32'h1234);
    check("pin_cnt", 32'(digit_cnt), 32'd4);
    press(11);
    check("check_state", 32'(state), 32'd1);
    idle(1);
    check("open_state", 32'(state), 32'd2);
    check("open_unlocked", 32'(unlocked), 32'd1);
    press(11);

    // overflow digit dropped; '*' clears mid-entry
    press(1); press(2); press(3); press(4); press(5);
    check("drop_buf", 32'(entry_buf), 32'h1234);
    press(11); idle(1);
    check("drop_unlocked", 32'(unlocked), 32'd1);
    press(11);
    press(1); press(2); press(10); press(3); press(4);
    check("star_buf", 32'(entry_buf), 32'h0034);
    check("star_cnt", 32'(digit_cnt), 32'd2);
    press(10);

    // three failures -> lockout of exactly LOCK_CYCLES
    for (int i = 1; i <= 3; i++) begin
      enter_pin(9, 9, 9, 9);
      idle(1);
      check("fail_pulse_seq", 32'(fail_pulse), 32'd1);
      check("fail_cnt_seq", 32'(fail_cnt), 32'(i));
    end
    check("lock_state", 32'(state), 32'd4);
    check("lock_locked", 32'(locked), 32'd1);
    idle(3); press(1); press(11); press(10);
    idle(6);
    check("lock_last", 32'(state), 32'd4);
    idle(1);
    check("lock_exit", 32'(state), 32'd0);
    check("lock_exit_fail", 32'(fail_cnt), 32'd0);

    // short entry fails, then correct PIN clears the count
    press(1); press(2); press(11); idle(1);
    check("short_pulse", 32'(fail_pulse), 32'd1);
    check("short_fail", 32'(fail_cnt), 32'd1);
    check("short_buf", 32'(entry_buf), 32'd0);
    enter_pin(1, 2, 3, 4); idle(1);
    check("short_unlock", 32'(unlocked), 32'd1);
    check("short_clear", 32'(fail_cnt), 32'd0);

    // change PIN to 5678
    press(10); press(5); press(6); press(7); press(8); press(11);
    check("set_done", 32'(set_done), 32'd1);
    check("set_open", 32'(state), 32'd2);
    press(11);
    enter_pin(1, 2, 3, 4); idle(1);
    check("old_pin_fail", 32'(fail_pulse), 32'd1);
    enter_pin(5, 6, 7, 8); idle(1);
    check("new_pin_open", 32'(unlocked), 32'd1);
    press(10); press(5); press(11);
    check("short_set_state", 32'(state), 32'd3);
    check("short_set_cnt", 32'(digit_cnt), 32'd1);
    press(10);
    check("abort_state", 32'(state), 32'd2);
    press(11);
    enter_pin(5, 6, 7, 8); idle(1);
    check("abort_kept_pin", 32'(unlocked), 32'd1);

    // async reset mid-SET restores DEFAULT_PIN
    press(10); press(5); press(6);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    idle(2);
    rst_n = 1'b1;
    enter_pin(1, 2, 3, 4); idle(1);
    check("midrst_unlock", 32'(unlocked), 32'd1);
    press(11);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      int r = $urandom_range(0, 9);
      if (r <= 3) begin
        for (int i = 0; i < PIN_LEN; i++) begin
          if ($urandom_range(0, 3) == 0) press($urandom_range(0, 9));
          else press(m_stored[i]);
        end
        press(11);
      end else if (r <= 5) begin
        repeat ($urandom_range(1, 4)) press($urandom_range(0, 15));
      end else if (r == 6) begin
        press(10);
        repeat ($urandom_range(2, 5)) press($urandom_range(0, 9));
        press(11);
      end else if (r == 7) press(10);
      else if (r == 8) press(11);
      else idle($urandom_range(0, 5));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
